// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the microprogrammed RV32 control unit.
package cpu_ctrl_pkg;

  localparam int unsigned UPC_W = 4;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_SHAMT = 3'd4
  } imm_type_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    PC_PC4     = 2'd0,
    PC_BR_COND = 2'd1,
    PC_JALR    = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    NEXT_SEQ      = 2'd0,
    NEXT_DISPATCH = 2'd1,
    NEXT_FETCH    = 2'd2,
    NEXT_HOLD     = 2'd3
  } next_sel_e;

  // Datapath-facing strobes of one micro-word
  typedef struct packed {
    logic      imem_req;
    logic      ir_we;
    logic      dmem_req;
    logic      dmem_we;
    logic      alu_src_imm;
    imm_type_e imm_type;
    logic      reg_we;
    wb_sel_e   wb_sel;
    logic      pc_we;
    pc_sel_e   pc_sel;
  } strobes_t;

  typedef struct packed {
    strobes_t  strobes;
    next_sel_e next_sel;
    logic      wait_mem;
  } uword_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [UPC_W-1:0] UPC_FETCH   = UPC_W'(0);
  localparam logic [UPC_W-1:0] UPC_DECODE  = UPC_W'(1);
  localparam logic [UPC_W-1:0] UPC_LD_ADDR = UPC_W'(2);
  localparam logic [UPC_W-1:0] UPC_LD_MEM  = UPC_W'(3);
  localparam logic [UPC_W-1:0] UPC_LD_WB   = UPC_W'(4);
  localparam logic [UPC_W-1:0] UPC_ST_ADDR = UPC_W'(5);
  localparam logic [UPC_W-1:0] UPC_ST_MEM  = UPC_W'(6);
  localparam logic [UPC_W-1:0] UPC_R_EX    = UPC_W'(7);
  localparam logic [UPC_W-1:0] UPC_I_EX    = UPC_W'(8);
  localparam logic [UPC_W-1:0] UPC_BR_EX   = UPC_W'(9);
  localparam logic [UPC_W-1:0] UPC_JALR_EX = UPC_W'(10);
  localparam logic [UPC_W-1:0] UPC_UNUSED0 = UPC_W'(11);
  localparam logic [UPC_W-1:0] UPC_TRAP    = UPC_W'(15);

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode store: micro-PC to micro-word.
module microcode_rom
  import cpu_ctrl_pkg::*;
(
  input  logic [UPC_W-1:0] upc,
  output uword_t           uword
);

  always_comb begin
    uword = '0;
    case (upc)
      UPC_FETCH: begin
        uword.strobes.imem_req = 1'b1;
        uword.strobes.ir_we    = 1'b1;
        uword.wait_mem         = 1'b1;
        uword.next_sel         = NEXT_SEQ;
      end
      UPC_DECODE: uword.next_sel = NEXT_DISPATCH;
      UPC_LD_ADDR: begin
        uword.strobes.imm_type    = IMM_I;
        uword.strobes.alu_src_imm = 1'b1;
        uword.next_sel            = NEXT_SEQ;
      end
      UPC_LD_MEM: begin
        uword.strobes.dmem_req = 1'b1;
        uword.wait_mem         = 1'b1;
        uword.next_sel         = NEXT_SEQ;
      end
      UPC_LD_WB: begin
        uword.strobes.reg_we = 1'b1;
        uword.strobes.wb_sel = WB_MEM;
        uword.strobes.pc_we  = 1'b1;
        uword.next_sel       = NEXT_FETCH;
      end
      UPC_ST_ADDR: begin
        uword.strobes.imm_type = IMM_S;
        uword.next_sel         = NEXT_SEQ;
      end
      UPC_ST_MEM: begin
        uword.strobes.dmem_req = 1'b1;
        uword.strobes.dmem_we  = 1'b1;
        uword.strobes.pc_we    = 1'b1;
        uword.wait_mem         = 1'b1;
        uword.next_sel         = NEXT_FETCH;
      end
      UPC_R_EX: begin
        uword.strobes.reg_we = 1'b1;
        uword.strobes.wb_sel = WB_ALU;
        uword.strobes.pc_we  = 1'b1;
        uword.next_sel       = NEXT_FETCH;
      end
      // Shift-immediate override of IMM_I happens in the sequencer
      UPC_I_EX: begin
        uword.strobes.imm_type    = IMM_I;
        uword.strobes.alu_src_imm = 1'b1;
        uword.strobes.reg_we      = 1'b1;
        uword.strobes.pc_we       = 1'b1;
        uword.next_sel            = NEXT_FETCH;
      end
      UPC_BR_EX: begin
        uword.strobes.imm_type = IMM_B;
        uword.strobes.pc_sel   = PC_BR_COND;
        uword.strobes.pc_we    = 1'b1;
        uword.next_sel         = NEXT_FETCH;
      end
      UPC_JALR_EX: begin
        uword.strobes.imm_type = IMM_I;
        uword.strobes.wb_sel   = WB_PC4;
        uword.strobes.reg_we   = 1'b1;
        uword.strobes.pc_sel   = PC_JALR;
        uword.strobes.pc_we    = 1'b1;
        uword.next_sel         = NEXT_FETCH;
      end
      default: uword.next_sel = NEXT_HOLD;
    endcase
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Micro-PC sequencer: dispatch, memory-wait gating, illegal-opcode trap and retire counter.
module microcode_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic                 mem_ready,
  output logic [UPC_W-1:0]     upc,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 alu_src_imm,
  output logic [2:0]           imm_type,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  logic [UPC_W-1:0]     upc_q;
  logic [UPC_W-1:0]     upc_d;
  logic [UPC_W-1:0]     dispatch_upc;
  logic                 illegal_q;
  logic [INSTRET_W-1:0] instret_q;
  logic                 stall;
  uword_t               uword;
  strobes_t             ctl;
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

  microcode_rom u_rom (
    .upc   (upc_q),
    .uword (uword)
  );

  always_comb begin
    dispatch_upc = UPC_TRAP;
    case (opcode)
      OPC_LOAD:   dispatch_upc = UPC_LD_ADDR;
      OPC_STORE:  dispatch_upc = UPC_ST_ADDR;
      OPC_OP:     dispatch_upc = UPC_R_EX;
      OPC_OP_IMM: dispatch_upc = UPC_I_EX;
      OPC_BRANCH: dispatch_upc = UPC_BR_EX;
      OPC_JALR:   dispatch_upc = UPC_JALR_EX;
      default:    dispatch_upc = UPC_TRAP;
    endcase
  end

  // A waiting micro-word holds the uPC until the memory acknowledges
  always_comb begin
    stall = uword.wait_mem & ~mem_ready;
    upc_d = upc_q;
    case (uword.next_sel)
      NEXT_SEQ:      upc_d = upc_q + UPC_W'(1);
      NEXT_DISPATCH: upc_d = dispatch_upc;
      NEXT_FETCH:    upc_d = UPC_FETCH;
      default:       upc_d = upc_q;
    endcase
    if (stall) begin
      upc_d = upc_q;
    end
  end

  // Requests stay up while stalled; only the completing cycle commits state
  always_comb begin
    ctl = uword.strobes;
    if (upc_q == UPC_I_EX && (funct3 == 3'b001 || funct3 == 3'b101)) begin
      ctl.imm_type = IMM_SHAMT;
    end
    if (stall) begin
      ctl.ir_we  = 1'b0;
      ctl.reg_we = 1'b0;
      ctl.pc_we  = 1'b0;
    end
    if (reset) begin
      ctl = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upc_q     <= UPC_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      upc_q <= upc_d;
      if (upc_d >= UPC_UNUSED0) begin
        illegal_q <= 1'b1;
      end
      if (ctl.pc_we) begin
        instret_q <= instret_q + INSTRET_W'(1);
      end
    end
  end

  assign upc         = upc_q;
  assign imem_req    = ctl.imem_req;
  assign ir_we       = ctl.ir_we;
  assign dmem_req    = ctl.dmem_req;
  assign dmem_we     = ctl.dmem_we;
  assign alu_src_imm = ctl.alu_src_imm;
  assign imm_type    = ctl.imm_type;
  assign reg_we      = ctl.reg_we;
  assign wb_sel      = ctl.wb_sel;
  assign pc_we       = ctl.pc_we;
  assign pc_sel      = ctl.pc_sel;
  assign illegal     = illegal_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: per-instruction cycle model feeds a queue,
// a negedge monitor compares every presented cycle.
module tb_microcode_sequencer;

  // Narrow retire counter so wrap-around is reached in a short run
  localparam int unsigned IW = 5;

  typedef struct packed {
    logic [3:0]    upc;
    logic          imem_req;
    logic          ir_we;
    logic          dmem_req;
    logic          dmem_we;
    logic          alu_src_imm;
    logic [2:0]    imm_type;
    logic          reg_we;
    logic [1:0]    wb_sel;
    logic          pc_we;
    logic [1:0]    pc_sel;
    logic          illegal;
    logic [IW-1:0] instret;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   instr = '0;
  logic          mem_ready = 1'b0;
  logic [3:0]    upc;
  logic          imem_req, ir_we, dmem_req, dmem_we, alu_src_imm;
  logic [2:0]    imm_type;
  logic          reg_we;
  logic [1:0]    wb_sel;
  logic          pc_we;
  logic [1:0]    pc_sel;
  logic          illegal;
  logic [IW-1:0] instret;

  microcode_sequencer #(.INSTRET_W(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .mem_ready   (mem_ready),
    .upc         (upc),
    .imem_req    (imem_req),
    .ir_we       (ir_we),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .alu_src_imm (alu_src_imm),
    .imm_type    (imm_type),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .illegal     (illegal),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  obs_t          exp_q[$];
  obs_t          mon_act;
  obs_t          mon_exp;
  int            checks = 0;
  int            failures = 0;
  logic [IW-1:0] m_instret = '0;
  logic          m_illegal = 1'b0;

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Expected view of a cycle with no strobes active
  function automatic obs_t idle(input logic [3:0] u);
    obs_t o;
    o = '0;
    o.upc     = u;
    o.illegal = m_illegal;
    o.instret = m_instret;
    return o;
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1100011 || op == 7'b1100111;
  endfunction

  task automatic step(input logic rst, input logic rdy, input obs_t e);
    reset     = rst;
    mem_ready = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Completing cycle of an instruction: the counter shows the increment afterwards
  task automatic retire(input obs_t e);
    step(1'b0, rbit(), e);
    m_instret = m_instret + IW'(1);
  endtask

  task automatic fetch_decode(input int wf);
    obs_t e;
    for (int i = 0; i < wf; i++) begin
      e = idle(4'd0); e.imem_req = 1'b1;
      step(1'b0, 1'b0, e);
    end
    e = idle(4'd0); e.imem_req = 1'b1; e.ir_we = 1'b1;
    step(1'b0, 1'b1, e);
    step(1'b0, rbit(), idle(4'd1));
  endtask

  task automatic run_instr(input logic [31:0] ins, input int wf, input int wm);
    obs_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    op    = ins[6:0];
    f3    = ins[14:12];
    instr = ins;
    fetch_decode(wf);
    case (op)
      7'b0000011: begin
        e = idle(4'd2); e.imm_type = 3'd1; e.alu_src_imm = 1'b1;
        step(1'b0, rbit(), e);
        for (int i = 0; i < wm; i++) begin
          e = idle(4'd3); e.dmem_req = 1'b1;
          step(1'b0, 1'b0, e);
        end
        e = idle(4'd3); e.dmem_req = 1'b1;
        step(1'b0, 1'b1, e);
        e = idle(4'd4); e.reg_we = 1'b1; e.wb_sel = 2'd1; e.pc_we = 1'b1;
        retire(e);
      end
      7'b0100011: begin
        e = idle(4'd5); e.imm_type = 3'd2;
        step(1'b0, rbit(), e);
        for (int i = 0; i < wm; i++) begin
          e = idle(4'd6); e.dmem_req = 1'b1; e.dmem_we = 1'b1;
          step(1'b0, 1'b0, e);
        end
        e = idle(4'd6); e.dmem_req = 1'b1; e.dmem_we = 1'b1; e.pc_we = 1'b1;
        reset = 1'b0; mem_ready = 1'b1; exp_q.push_back(e);
        @(posedge clk); #1;
        m_instret = m_instret + IW'(1);
      end
      7'b0110011: begin
        e = idle(4'd7); e.reg_we = 1'b1; e.pc_we = 1'b1;
        retire(e);
      end
      7'b0010011: begin
        e = idle(4'd8); e.alu_src_imm = 1'b1; e.reg_we = 1'b1; e.pc_we = 1'b1;
        e.imm_type = (f3 == 3'b001 || f3 == 3'b101) ? 3'd4 : 3'd1;
        retire(e);
      end
      7'b1100011: begin
        e = idle(4'd9); e.imm_type = 3'd3; e.pc_sel = 2'd1; e.pc_we = 1'b1;
        retire(e);
      end
      7'b1100111: begin
        e = idle(4'd10); e.imm_type = 3'd1; e.wb_sel = 2'd2; e.reg_we = 1'b1;
        e.pc_sel = 2'd2; e.pc_we = 1'b1;
        retire(e);
      end
      default: begin
        // Trap is sticky and silent until reset
        m_illegal = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, rbit(), idle(4'd15));
        step(1'b1, rbit(), idle(4'd15));
        m_illegal = 1'b0;
        m_instret = '0;
      end
    endcase
  endtask

  task automatic reset_in_fetch(input logic [31:0] ins, input int wf);
    obs_t e;
    instr = ins;
    for (int i = 0; i < wf; i++) begin
      e = idle(4'd0); e.imem_req = 1'b1;
      step(1'b0, 1'b0, e);
    end
    step(1'b1, rbit(), idle(4'd0));
    m_illegal = 1'b0;
    m_instret = '0;
  endtask

  function automatic logic [31:0] rand_instr(input int k);
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case (k)
      0:       op = 7'b0000011;
      1:       op = 7'b0100011;
      2:       op = 7'b0110011;
      3:       op = 7'b0010011;
      4:       op = 7'b1100011;
      5:       op = 7'b1100111;
      default: begin
        op = 7'($urandom);
        while (is_legal(op)) op = 7'($urandom);
      end
    endcase
    return {r[31:7], op};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {upc, imem_req, ir_we, dmem_req, dmem_we, alu_src_imm, imm_type,
                 reg_we, wb_sel, pc_we, pc_sel, illegal, instret};
      checks++;
      if (mon_act !== mon_exp) begin
        failures++;
        $display("FAIL cycle_check t=%0t upc exp=%0d act=%0d: actual=%h required=%h",
                 $time, mon_exp.upc, mon_act.upc, mon_act, mon_exp);
      end
    end
  end

  initial begin
    int c;
    reset = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_instr(32'h002081B3, 0, 0);
    run_instr(32'h0000A103, 0, 2);
    run_instr(32'h00309093, 1, 0);
    run_instr(32'h00108093, 0, 0);
    run_instr(32'h0000007F, 0, 0);
    run_instr(32'h002081B3, 0, 0);
    reset_in_fetch(32'h002081B3, 2);
    for (int i = 0; i < (1 << IW) - 1; i++) run_instr(32'h00108093, 0, 0);
    run_instr(32'h00000063, 0, 0);
    run_instr(32'h00000067, 1, 0);
    run_instr(32'h00112023, 0, 1);
    for (int n = 0; n < 300; n++) begin
      c = $urandom_range(0, 31);
      if (c == 31) run_instr(rand_instr(6), $urandom_range(0, 2), 0);
      else if (c == 30) reset_in_fetch(rand_instr(2), $urandom_range(1, 3));
      else run_instr(rand_instr(c % 6), $urandom_range(0, 2), $urandom_range(0, 3));
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
